// File: rtl/snake_body_engine.sv
// Snake game state engine: head registers plus a circular segment buffer, one move per step.
// Optional SNAKE_WRAP_EN macro turns the playfield into a torus (no boundary lose).
module snake_body_engine #(
   parameter int GRID_W  = 50,
   parameter int GRID_H  = 50,
   parameter int COORD_W = 6,
   parameter int ADDR_W  = 8
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic               step,
   input  logic               dir_valid,
   input  logic [1:0]         dir,
   input  logic               grow,
   output logic               busy,
   output logic               step_done,
   output logic               lose,
   output logic [COORD_W-1:0] head_x,
   output logic [COORD_W-1:0] head_y,
   output logic [ADDR_W:0]    length,
   input  logic [ADDR_W-1:0]  rd_idx,
   output logic [COORD_W-1:0] rd_x,
   output logic [COORD_W-1:0] rd_y,
   output logic               rd_valid
);

   localparam int MAX_LEN = 2**ADDR_W;
   localparam int LEN_W   = ADDR_W + 1;
   localparam int SEG_W   = 2 * COORD_W;
   localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(MAX_LEN);
   localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(GRID_W - 1);
   localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(GRID_H - 1);
   localparam logic [COORD_W-1:0] X_MID   = COORD_W'(GRID_W / 2);
   localparam logic [COORD_W-1:0] Y_MID   = COORD_W'(GRID_H / 2);
   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_RIGHT = 2'b01;
   localparam logic [1:0] DIR_DOWN  = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_COMMIT, S_DEAD} state_t;
   state_t state, state_nxt;

   logic [SEG_W-1:0]   mem [MAX_LEN];
   logic [SEG_W-1:0]   eng_q, rd_q;
   logic [1:0]         cur_dir, pend_dir, eff_dir;
   logic               grow_pending, move_grow, lose_pending;
   logic [COORD_W-1:0] cand_x, cand_y, nx, ny;
   logic [ADDR_W-1:0]  base, eng_addr, rd_addr;
   logic [LEN_W-1:0]   cnt, scan_n, scan_len;
   logic               dir_ok, growing, bound_fail, seg_hit, commit_wr;

   // dir is consumed in any cycle dir_valid is high; there is no ready, reverses are silently dropped.
   assign dir_ok    = dir_valid && (dir != ~cur_dir);
   assign eff_dir   = dir_ok ? dir : pend_dir;
   assign growing   = grow_pending | grow;
   assign eng_addr  = base + cnt[ADDR_W-1:0] + ADDR_W'(1);
   assign rd_addr   = base + rd_idx;
   assign seg_hit   = (cnt != '0) && (eng_q == {cand_x, cand_y});
   assign commit_wr = (state == S_COMMIT) && !lose_pending && !reset;
   assign busy      = (state == S_CHECK) || (state == S_COMMIT);
   assign rd_x      = rd_q[SEG_W-1:COORD_W];
   assign rd_y      = rd_q[COORD_W-1:0];

   // The tail is excluded from the scan when not growing because it vacates this move.
   always_comb begin
      scan_len = '0;
      if (growing)
         scan_len = length - LEN_W'(1);
      else if (length >= LEN_W'(2))
         scan_len = length - LEN_W'(2);
   end

   always_comb begin
      nx = head_x;
      ny = head_y;
      bound_fail = 1'b0;
      case (eff_dir)
         DIR_UP:    ny = head_y - COORD_W'(1);
         DIR_DOWN:  ny = head_y + COORD_W'(1);
         DIR_RIGHT: nx = head_x + COORD_W'(1);
         default:   nx = head_x - COORD_W'(1);
      endcase
`ifdef SNAKE_WRAP_EN
      if ((eff_dir == DIR_UP) && (head_y == '0))       ny = Y_LAST;
      if ((eff_dir == DIR_DOWN) && (head_y == Y_LAST)) ny = '0;
      if ((eff_dir == 2'b10) && (head_x == '0))        nx = X_LAST;
      if ((eff_dir == DIR_RIGHT) && (head_x == X_LAST)) nx = '0;
`else
      bound_fail = (nx > X_LAST) || (ny > Y_LAST);
`endif
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (step) state_nxt = S_CHECK;
         S_CHECK:  if (cnt == scan_n) state_nxt = S_COMMIT;
         S_COMMIT: state_nxt = lose_pending ? S_DEAD : S_IDLE;
         default:  state_nxt = S_DEAD;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state        <= S_IDLE;
         head_x       <= X_MID;
         head_y       <= Y_MID;
         length       <= LEN_W'(1);
         cur_dir      <= DIR_UP;
         pend_dir     <= DIR_UP;
         grow_pending <= 1'b0;
         move_grow    <= 1'b0;
         lose_pending <= 1'b0;
         lose         <= 1'b0;
         step_done    <= 1'b0;
         base         <= '0;
         cnt          <= '0;
         scan_n       <= '0;
         cand_x       <= '0;
         cand_y       <= '0;
         rd_valid     <= 1'b0;
      end else begin
         state     <= state_nxt;
         step_done <= 1'b0;
         rd_valid  <= {1'b0, rd_idx} < length;
         if (dir_ok) pend_dir <= dir;
         if (grow) grow_pending <= 1'b1;
         case (state)
            S_IDLE: if (step) begin
               cur_dir      <= eff_dir;
               pend_dir     <= eff_dir;
               cand_x       <= nx;
               cand_y       <= ny;
               lose_pending <= bound_fail;
               move_grow    <= growing;
               scan_n       <= scan_len;
               cnt          <= '0;
            end
            S_CHECK: begin
               cnt <= cnt + LEN_W'(1);
               if (seg_hit) lose_pending <= 1'b1;
            end
            S_COMMIT: begin
               grow_pending <= 1'b0;
               step_done    <= 1'b1;
               if (lose_pending) begin
                  lose <= 1'b1;
               end else begin
                  head_x <= cand_x;
                  head_y <= cand_y;
                  base   <= base - ADDR_W'(1);
                  if (move_grow && (length != LEN_MAX)) length <= length + LEN_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Buffer: engine port (scan read / commit write) and render read port; reads see pre-write data.
   always_ff @(posedge CLOCK_50) begin
      if (commit_wr) mem[base] <= {head_x, head_y};
      eng_q <= mem[eng_addr];
      rd_q  <= (rd_idx == '0) ? {head_x, head_y} : mem[rd_addr];
   end

endmodule

// File: tb/tb_snake_body_engine.sv
// Self-checking bench for snake_body_engine: queue-based body model, directed and random moves.
module tb_snake_body_engine;

   localparam int GW = 50;
   localparam int GH = 50;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       step = 1'b0, dir_valid = 1'b0, grow = 1'b0;
   logic [1:0] dir = 2'b00;
   logic [7:0] rd_idx = 8'd0;
   logic       busy, step_done, lose, rd_valid;
   logic [5:0] head_x, head_y, rd_x, rd_y;
   logic [8:0] length;

   int errors = 0;
   int checks = 0;

   // reference model: exp_q[0] is the head, each entry {x,y}
   logic [11:0] exp_q[$];
   logic [1:0]  m_cur, m_pend;
   bit          m_grow, m_lose;

   snake_body_engine dut (
      .CLOCK_50(clk), .reset(reset), .step(step), .dir_valid(dir_valid), .dir(dir),
      .grow(grow), .busy(busy), .step_done(step_done), .lose(lose),
      .head_x(head_x), .head_y(head_y), .length(length),
      .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_q.push_back({6'(GW / 2), 6'(GH / 2)});
      m_cur = 2'b00;
      m_pend = 2'b00;
      m_grow = 0;
      m_lose = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; step = 0; dir_valid = 0; grow = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic check_state(input string tag);
      check({tag, "_hx"}, head_x, exp_q[0][11:6]);
      check({tag, "_hy"}, head_y, exp_q[0][5:0]);
      check({tag, "_len"}, length, exp_q.size());
      check({tag, "_lose"}, lose, m_lose);
   endtask

   // one-cycle dir/grow request in IDLE, no step
   task automatic pulse(input logic dv, input logic [1:0] d, input logic g);
      @(negedge clk);
      dir_valid = dv; dir = d; grow = g;
      @(posedge clk);
      @(negedge clk);
      dir_valid = 0; grow = 0;
      if (dv && (d != ~m_cur)) m_pend = d;
      if (g) m_grow = 1;
   endtask

   task automatic do_step(input logic dv, input logic [1:0] d, input logic g);
      int hx, hy, cx, cy, n, k, len;
      bit growing, hit, out, seen;
      if (m_lose) begin
         @(negedge clk);
         step = 1; dir_valid = dv; dir = d; grow = g;
         @(negedge clk);
         step = 0; dir_valid = 0; grow = 0;
         seen = 0;
         repeat (8) begin
            @(negedge clk);
            if (step_done || busy) seen = 1;
         end
         check("dead_ignored", seen, 0);
         check_state("dead");
         return;
      end
      if (dv && (d != ~m_cur)) m_pend = d;
      m_cur = m_pend;
      growing = m_grow | g;
      hx = int'(exp_q[0][11:6]);
      hy = int'(exp_q[0][5:0]);
      cx = hx; cy = hy;
      case (m_cur)
         2'b00: cy = hy - 1;
         2'b11: cy = hy + 1;
         2'b01: cx = hx + 1;
         default: cx = hx - 1;
      endcase
`ifdef SNAKE_WRAP_EN
      cx = (cx + GW) % GW;
      cy = (cy + GH) % GH;
      out = 0;
`else
      out = (cx < 0) || (cx >= GW) || (cy < 0) || (cy >= GH);
`endif
      len = exp_q.size();
      n = growing ? len - 1 : ((len >= 2) ? len - 2 : 0);
      hit = 0;
      for (int i = 1; i <= n; i++)
         if (exp_q[i] == {6'(cx), 6'(cy)}) hit = 1;

      @(negedge clk);
      step = 1; dir_valid = dv; dir = d; grow = g;
      @(posedge clk);
      @(negedge clk);
      dir_valid = 0; grow = 0;
      check("busy_in_check", busy, 1);
      // a second step while busy must be ignored
      k = 0;
      seen = 0;
      while (k < 300 && !seen) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         step = 0;
         if (step_done) seen = 1;
      end
      check("latency", k, n + 2);

      m_grow = 0;
      if (hit || out) begin
         m_lose = 1;
      end else begin
         exp_q.push_front({6'(cx), 6'(cy)});
         if (!(growing && len < 256)) void'(exp_q.pop_back());
      end
      check_state("move");
      @(negedge clk);
      check("done_pulse", step_done, 0);
   endtask

   task automatic rd_check(input int idx);
      @(negedge clk);
      rd_idx = 8'(idx);
      @(posedge clk);
      @(negedge clk);
      check("rd_valid", rd_valid, (idx < exp_q.size()) ? 1 : 0);
      if (idx < exp_q.size()) begin
         check("rd_x", rd_x, exp_q[idx][11:6]);
         check("rd_y", rd_y, exp_q[idx][5:0]);
      end
   endtask

   initial begin
      model_reset();
      do_reset();
      check("rst_busy", busy, 0);
      check("rst_done", step_done, 0);
      check_state("rst");

      // basic moves, reverse filter, turn
      do_step(0, 2'b00, 0);
      pulse(1, 2'b11, 0);
      do_step(0, 2'b00, 0);
      pulse(1, 2'b01, 0);
      do_step(0, 2'b00, 0);
      // grow with step, read port
      do_step(0, 2'b00, 1);
      rd_check(0);
      rd_check(1);
      rd_check(2);

      // top wall, then dead
      do_reset();
      do_step(0, 2'b00, 1);
      rd_check(1);
      for (int i = 0; i < 25; i++) do_step(0, 2'b00, 0);
      do_step(0, 2'b00, 0);
      do_step(0, 2'b00, 0);

      // left wall (wraps when the torus is enabled)
      do_reset();
      for (int i = 0; i < 15; i++) do_step(0, 2'b00, 0);
      do_step(1, 2'b10, 0);
      for (int i = 0; i < 25; i++) do_step(0, 2'b10, 0);
      do_step(0, 2'b10, 0);

      // self-collision at length 5
      do_reset();
      for (int i = 0; i < 4; i++) do_step(0, 2'b00, 1);
      do_step(1, 2'b01, 0);
      do_step(1, 2'b11, 0);
      do_step(1, 2'b10, 0);
      check("loop5_lose", lose, 1);
      // same loop at length 4: only the vacating tail overlaps
      do_reset();
      pulse(0, 2'b00, 1);
      do_step(0, 2'b00, 0);
      for (int i = 0; i < 2; i++) do_step(0, 2'b00, 1);
      do_step(1, 2'b01, 0);
      do_step(1, 2'b11, 0);
      do_step(1, 2'b10, 0);
      check("loop4_lose", lose, 0);
      for (int i = 0; i < 5; i++) rd_check(i);

      // reset in the middle of a move
      @(negedge clk);
      step = 1;
      @(negedge clk);
      step = 0;
      reset = 1;
      @(negedge clk);
      reset = 0;
      model_reset();
      begin
         bit seen = 0;
         repeat (6) begin
            @(negedge clk);
            if (step_done) seen = 1;
         end
         check("abort_no_done", seen, 0);
      end
      check_state("abort");

      // random play
      for (int s = 0; s < 250; s++) begin
         if (m_lose) begin
            do_step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 0);
            do_reset();
         end else begin
            if ($urandom_range(0, 9) < 2)
               pulse(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));
            do_step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));
            rd_check($urandom_range(0, exp_q.size() + 1));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
